// File: rtl/route_demux.sv
// route_demux
//   Input-side demultiplexer of a mesh router. Each incoming flit is steered to
//   the input buffer of its virtual channel, and the next hop is computed with
//   XY dimension-order routing. All outputs are registered, one cycle after the
//   flit is presented.
//
//   Optional feature: define ROUTE_DEMUX_CHECK_EN to enable per-VC packet
//   protocol checking. This covers framing, full-buffer drops and the error
//   pulse. Without it, every valid flit with an in-range vc_id is written and
//   error_o is tied low.
//
//   Flit layout (MSB..LSB):
//     data_i : {label[1:0], vc_id[VC_ID_W-1:0], payload[15:0]}
//     data_o : {label[1:0], payload[15:0]}   (vc_id stripped)
//   On head flits, payload[7:4] is x_dest and payload[3:0] is y_dest.
//   Label encoding: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
//   Port encoding : LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4.
//
//   Ports:
//     clk         clock, rising edge
//     resetn      asynchronous active-low reset
//     data_i      flit from the upstream link
//     valid_i     data_i carries a flit this cycle
//     is_full_i   per-VC input buffer full flags
//     data_o      registered flit without its vc_id
//     write_o     one-hot per-VC write strobe, aligned with data_o
//     out_port_o  routed next hop, aligned with data_o
//     error_o     one-cycle protocol-violation pulse, aligned with data_o
//
//   Per-VC FSM (present only when checking is enabled):
//     state | meaning
//     IDLE  | between packets; expecting HEAD or HEADTAIL
//     PKT   | inside a packet; expecting BODY or TAIL
module route_demux #(
  parameter int VC_NUM    = 2,
  parameter int X_CURRENT = 0,
  parameter int Y_CURRENT = 0,
  localparam int VC_SIZE  = $clog2(VC_NUM),
  localparam int VC_ID_W  = (VC_SIZE < 1) ? 1 : VC_SIZE,
  localparam int FLIT_W   = 18 + VC_ID_W,
  localparam int NOVC_W   = 18
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              valid_i,
  input  logic [VC_NUM-1:0] is_full_i,
  output logic [NOVC_W-1:0] data_o,
  output logic [VC_NUM-1:0] write_o,
  output logic [2:0]        out_port_o,
  output logic              error_o
);

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4} port_t;

  localparam logic [3:0] X_CUR = 4'(X_CURRENT);
  localparam logic [3:0] Y_CUR = 4'(Y_CURRENT);

  flit_label_t       label;
  logic [31:0]       vc_ext;
  logic [15:0]       payload;
  logic              is_head;
  logic              vc_ok;
  logic              drop;
  logic              accept;
  port_t             route;
  port_t             lat_sel;
  port_t             out_d;
  logic [NOVC_W-1:0] data_d;
  logic [VC_NUM-1:0] write_d;
  port_t             port_lat_q [VC_NUM];
  port_t             port_lat_d [VC_NUM];

  assign label   = flit_label_t'(data_i[FLIT_W-1 -: 2]);
  assign vc_ext  = 32'(data_i[16 +: VC_ID_W]);
  assign payload = data_i[15:0];
  assign is_head = (label == HEAD) || (label == HEADTAIL);
  // Not a constant check: vc_id can be out of range when VC_NUM is not a power of two.
  assign vc_ok   = (vc_ext < 32'(VC_NUM));

  always_comb begin
    route = LOCAL;
    if (payload[7:4] > X_CUR)      route = EAST;
    else if (payload[7:4] < X_CUR) route = WEST;
    else if (payload[3:0] > Y_CUR) route = SOUTH;
    else if (payload[3:0] < Y_CUR) route = NORTH;
  end

`ifdef ROUTE_DEMUX_CHECK_EN
  typedef enum logic {VC_IDLE = 1'b0, VC_PKT = 1'b1} vc_state_t;

  vc_state_t state_q [VC_NUM];
  vc_state_t state_d [VC_NUM];
  vc_state_t cur_state;
  logic      full_sel;
  logic      proto_bad;
  logic      error_q;
  logic      error_d;

  assign error_o = error_q;
`else
  logic unused_full;

  assign unused_full = ^is_full_i;
  assign error_o     = 1'b0;
`endif

  always_comb begin
    lat_sel    = LOCAL;
    port_lat_d = port_lat_q;
    write_d    = '0;
    drop       = !vc_ok;
`ifdef ROUTE_DEMUX_CHECK_EN
    state_d   = state_q;
    cur_state = VC_IDLE;
    full_sel  = 1'b0;
    error_d   = 1'b0;
`endif

    for (int i = 0; i < VC_NUM; i++) begin
      if (vc_ext == 32'(i)) begin
        lat_sel = port_lat_q[i];
`ifdef ROUTE_DEMUX_CHECK_EN
        cur_state = state_q[i];
        full_sel  = is_full_i[i];
`endif
      end
    end

`ifdef ROUTE_DEMUX_CHECK_EN
    proto_bad = is_head ? (cur_state == VC_PKT) : (cur_state == VC_IDLE);
    drop      = !vc_ok || full_sel || proto_bad;
    error_d   = valid_i && drop;
`endif

    accept = valid_i && !drop;

    for (int i = 0; i < VC_NUM; i++) begin
      if (accept && (vc_ext == 32'(i))) begin
        write_d[i] = 1'b1;
        if (is_head) port_lat_d[i] = route;
`ifdef ROUTE_DEMUX_CHECK_EN
        if (label == HEAD)      state_d[i] = VC_PKT;
        else if (label == TAIL) state_d[i] = VC_IDLE;
`endif
      end
    end

    // Body/tail flits report the port latched by their VC's head.
    out_d  = valid_i ? (is_head ? route : lat_sel) : LOCAL;
    data_d = valid_i ? {label, payload} : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_o     <= '0;
      write_o    <= '0;
      out_port_o <= LOCAL;
      for (int i = 0; i < VC_NUM; i++) port_lat_q[i] <= LOCAL;
`ifdef ROUTE_DEMUX_CHECK_EN
      error_q <= 1'b0;
      for (int i = 0; i < VC_NUM; i++) state_q[i] <= VC_IDLE;
`endif
    end else begin
      data_o     <= data_d;
      write_o    <= write_d;
      out_port_o <= out_d;
      port_lat_q <= port_lat_d;
`ifdef ROUTE_DEMUX_CHECK_EN
      error_q <= error_d;
      state_q <= state_d;
`endif
    end
  end

endmodule

// File: tb/tb_route_demux.sv
// tb_route_demux
//   Testbench for route_demux with the router at mesh position (1,1).
//   A behavioural model predicts each output cycle from the packet rules.
//   Directed scenarios come first, followed by randomized traffic.
module tb_route_demux;

  localparam logic [2:0] P_LOCAL = 3'd0, P_NORTH = 3'd1, P_SOUTH = 3'd2,
                         P_WEST  = 3'd3, P_EAST  = 3'd4;
  localparam logic [1:0] L_HEAD = 2'd0, L_BODY = 2'd1, L_TAIL = 2'd2, L_HT = 2'd3;
`ifdef ROUTE_DEMUX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [18:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic [1:0]  is_full_i = '0;
  logic [17:0] data_o;
  logic [1:0]  write_o;
  logic [2:0]  out_port_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  // Model state: whether each VC is inside a packet, and its last head's port.
  bit         in_pkt [2];
  logic [2:0] lat    [2];

  route_demux #(.VC_NUM(2), .X_CURRENT(1), .Y_CURRENT(1)) dut (
    .clk(clk), .resetn(resetn), .data_i(data_i), .valid_i(valid_i),
    .is_full_i(is_full_i), .data_o(data_o), .write_o(write_o),
    .out_port_o(out_port_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] xy_route(input logic [3:0] x, input logic [3:0] y);
    if (x > 4'd1) return P_EAST;
    if (x < 4'd1) return P_WEST;
    if (y > 4'd1) return P_SOUTH;
    if (y < 4'd1) return P_NORTH;
    return P_LOCAL;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr"}, write_o, 0);
    chk({tag, "_err"}, error_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_port"}, out_port_o, P_LOCAL);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    valid_i = 1'b1;
    data_i = {L_BODY, 1'b0, 16'h1234};
    #1;
    chk_reset_outputs(tag);
    @(posedge clk); #1;
    chk_reset_outputs(tag);
    for (int i = 0; i < 2; i++) begin
      in_pkt[i] = 1'b0;
      lat[i] = P_LOCAL;
    end
    valid_i = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic step(input bit v, input logic [1:0] lab, input bit vc,
                      input logic [15:0] pl, input logic [1:0] full);
    bit         head, viol, acc;
    logic [1:0] ew;
    logic [2:0] ep;
    data_i = {lab, vc, pl};
    valid_i = v;
    is_full_i = full;
    head = (lab == L_HEAD) || (lab == L_HT);
    viol = CHK && (full[vc] || (head ? in_pkt[vc] : !in_pkt[vc]));
    acc = v && !viol;
    ew = acc ? (2'b01 << vc) : 2'b00;
    ep = head ? xy_route(pl[7:4], pl[3:0]) : lat[vc];
    @(posedge clk); #1;
    chk("write", write_o, ew);
    chk("error", error_o, v && viol);
    if (acc) begin
      chk("data", data_o, {lab, pl});
      chk("port", out_port_o, ep);
      if (head) lat[vc] = ep;
      if (lab == L_HEAD) in_pkt[vc] = 1'b1;
      else if (lab == L_TAIL) in_pkt[vc] = 1'b0;
    end
    valid_i = 1'b0;
  endtask

  initial begin
    bit         v, vc;
    logic [1:0] lab, full;
    logic [15:0] pl;

    do_reset("rst0");

    // Head to the east, followed by its tail.
    step(1, L_HEAD, 0, 16'h0030, 2'b00);
    chk("r29_wr", write_o, 2'b01);
    chk("r29_port", out_port_o, P_EAST);
    chk("r29_err", error_o, 0);
    step(1, L_TAIL, 0, 16'hBEEF, 2'b00);

    // A local packet on vc1, with the port latched across body and tail.
    step(1, L_HEAD, 1, 16'h0011, 2'b00);
    chk("r30_h_port", out_port_o, P_LOCAL);
    step(1, L_BODY, 1, 16'h5A47, 2'b00);
    chk("r30_b_wr", write_o, 2'b10);
    chk("r30_b_port", out_port_o, P_LOCAL);
    step(1, L_TAIL, 1, 16'hC3F2, 2'b00);
    chk("r30_t_wr", write_o, 2'b10);
    chk("r30_t_port", out_port_o, P_LOCAL);

    // Packets on vc0 and vc1 interleaved cycle by cycle.
    step(1, L_HEAD, 0, 16'h0001, 2'b00);
    chk("r31_p0", out_port_o, P_WEST);
    step(1, L_HEAD, 1, 16'h0012, 2'b00);
    chk("r31_p1", out_port_o, P_SOUTH);
    step(1, L_BODY, 0, 16'h4444, 2'b00);
    chk("r31_p2", out_port_o, P_WEST);
    chk("r31_w2", write_o, 2'b01);
    step(1, L_BODY, 1, 16'h3333, 2'b00);
    chk("r31_p3", out_port_o, P_SOUTH);
    chk("r31_w3", write_o, 2'b10);
    step(1, L_TAIL, 0, 16'h0000, 2'b00);
    step(1, L_TAIL, 1, 16'h0000, 2'b00);

    // A body immediately after reset, then a headtail to the north.
    do_reset("rst1");
    step(1, L_BODY, 0, 16'h7777, 2'b00);
    chk("r32_wr", write_o, CHK ? 2'b00 : 2'b01);
    chk("r32_err", error_o, CHK);
    step(1, L_HT, 0, 16'h0010, 2'b00);
    chk("r32_ht_port", out_port_o, P_NORTH);
    chk("r32_ht_err", error_o, 0);

    // A full buffer drops the flit; the next flit goes through once space frees.
    step(1, L_HEAD, 0, 16'h0021, 2'b00);
    step(1, L_BODY, 0, 16'h1111, 2'b01);
    chk("r33_wr", write_o, CHK ? 2'b00 : 2'b01);
    chk("r33_err", error_o, CHK);
    step(1, L_BODY, 0, 16'h2222, 2'b00);
    chk("r33_ok_wr", write_o, 2'b01);
    chk("r33_ok_err", error_o, 0);
    step(1, L_TAIL, 0, 16'h0000, 2'b00);

    // Reset mid-packet discards the open packet.
    step(1, L_HEAD, 0, 16'h0031, 2'b00);
    do_reset("rst2");
    step(1, L_BODY, 0, 16'h9999, 2'b00);
    chk("r34_err", error_o, CHK);
    step(0, L_HEAD, 0, 16'h0000, 2'b00);
    chk("idle_wr", write_o, 0);

    // Randomized traffic, biased toward well-formed packets.
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 4) != 0);
      vc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0)
        lab = in_pkt[vc] ? ($urandom_range(0, 1) ? L_BODY : L_TAIL)
                         : ($urandom_range(0, 1) ? L_HEAD : L_HT);
      else
        lab = 2'($urandom_range(0, 3));
      pl = 16'($urandom);
      pl[7:4] = 4'($urandom_range(0, 2));
      pl[3:0] = 4'($urandom_range(0, 2));
      full = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(v, lab, vc, pl, full);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/route_demux.md
ROUTE_DEMUX -- requirements
Module: route_demux

Interface
REQ-001 Parameter VC_NUM, default 2: virtual channels per input port; VC_SIZE = $clog2(VC_NUM).
REQ-002 Parameter X_CURRENT, default 0: mesh X coordinate of this router.
REQ-003 Parameter Y_CURRENT, default 0: mesh Y coordinate of this router.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 resetn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 data_i  input  flit_t  flit from upstream link; vc_id selects destination VC.
REQ-007 valid_i  input  1  data_i carries a flit this cycle.
REQ-008 is_full_i  input  VC_NUM  per-VC input_buffer full flags.
REQ-009 data_o  output  flit_novc_t  registered flit (label, data), vc_id stripped.
REQ-010 write_o  output  VC_NUM  one-hot per-VC write strobe, aligned with data_o.
REQ-011 out_port_o  output  port_t  routed next hop, aligned with data_o; meaningful on HEAD/HEADTAIL.
REQ-012 error_o  output  1  one-cycle protocol-violation pulse, aligned with data_o.

Function
REQ-013 Latency exactly 1 cycle: flit accepted in cycle N appears on data_o/write_o/out_port_o in cycle N+1.
REQ-014 write_o has at most one bit set; bit vc_id set only when flit accepted (REQ-019); all zero when valid_i low.
REQ-015 Routing is XY dimension-order on head_data.x_dest/y_dest: x_dest>X_CURRENT -> EAST; x_dest<X_CURRENT -> WEST; else y_dest>Y_CURRENT -> SOUTH; y_dest<Y_CURRENT -> NORTH; else LOCAL.
REQ-016 Routing evaluated only for HEAD/HEADTAIL; for BODY/TAIL out_port_o holds the value of the VC's last head (per-VC latched port).
REQ-017 Per-VC packet FSM, states IDLE and PKT; HEAD in IDLE -> PKT; HEADTAIL in IDLE stays IDLE; BODY in PKT stays PKT; TAIL in PKT -> IDLE.
REQ-018 Violations: BODY/TAIL in IDLE; HEAD/HEADTAIL in PKT; vc_id >= VC_NUM; any flit to VC whose is_full_i is high.
REQ-019 Violating flit dropped (write_o stays zero), FSM of that VC unchanged, error_o=1 in cycle N+1; non-violating flit accepted.
REQ-020 Flits to different VCs interleave freely cycle by cycle; each VC FSM advances independently.
REQ-021 Back-to-back flits every cycle sustained without bubbles; no internal backpressure.
REQ-022 HEAD to VC with is_full_i high: dropped, FSM stays IDLE, latched port unchanged.
REQ-023 is_full_i sampled in the same cycle as valid_i (combinational check, registered result).

Reset
REQ-024 While resetn low: write_o=0, error_o=0, data_o=0, out_port_o=LOCAL, all VC FSMs IDLE, latched ports LOCAL.
REQ-025 Reset asserted mid-packet discards packet state; after release, first flit per VC must be HEAD/HEADTAIL.
REQ-026 First flit accepted is the one presented on the first rising edge with resetn high.

Configuration
REQ-027 Macro ROUTE_DEMUX_CHECK_EN: defined -> REQ-017..REQ-019, REQ-022 checking active as specified.
REQ-028 ROUTE_DEMUX_CHECK_EN undefined -> no checks, every valid flit with in-range vc_id written, per-VC port latch still kept, error_o tied 0.

Verification
REQ-029 X_CURRENT=1,Y_CURRENT=1; HEAD vc0 dest (3,0) -> cycle+1 write_o=01, out_port_o=EAST, error_o=0.
REQ-030 HEAD vc1 dest (1,1), BODY vc1, TAIL vc1 consecutive cycles -> write_o=10 three cycles, out_port_o=LOCAL each, vc1 back to IDLE.
REQ-031 Interleave HEAD vc0 dest (0,1), HEAD vc1 dest (1,2), BODY vc0, BODY vc1 -> ports WEST, SOUTH, WEST, SOUTH; write_o 01,10,01,10.
REQ-032 CHECK_EN defined: BODY vc0 after reset -> write_o=00, error_o=1 one cycle; then HEADTAIL vc0 dest (1,0) -> write_o=01, NORTH.
REQ-033 CHECK_EN defined: is_full_i=01, BODY vc0 mid-packet -> dropped, error_o=1; next BODY vc0 with is_full_i=00 -> written, no error.
REQ-034 Assert resetn low during vc0 packet, release, send BODY vc0 -> error_o=1 (CHECK_EN defined), all outputs zero/LOCAL during reset.
